// File: rtl/paula_audio_decimator.sv
// Paula audio decimator: boxcar-averages 2^DECIM_LOG2 mixer ticks per
// channel and queues the averaged stereo words in a small output FIFO.
module paula_audio_decimator #(
    parameter int DECIM_LOG2 = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk7_en,
    input  logic        enable,
    input  logic [14:0] ldatasum,
    input  logic [14:0] rdatasum,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [15:0] out_left,
    output logic [15:0] out_right,
    output logic        overflow,
    output logic [7:0]  drop_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                state;
    logic signed [21:0]    lacc;
    logic signed [21:0]    racc;
    logic signed [21:0]    lsum;
    logic signed [21:0]    rsum;
    logic [14:0]           lavg;
    logic [14:0]           ravg;
    logic [DECIM_LOG2-1:0] cnt;
    logic [31:0]           mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW:0]           count;
    logic [PW:0]           count_next;
    logic                  tick;
    logic                  terminal;
    logic                  pop;
    logic                  full;
    logic                  push;
    logic                  drop;

    always_comb begin
        lsum = lacc + {{7{ldatasum[14]}}, ldatasum};
        rsum = racc + {{7{rdatasum[14]}}, rdatasum};
        lavg = 15'(lsum >>> DECIM_LOG2);
        ravg = 15'(rsum >>> DECIM_LOG2);
    end

    // A window already running may still finish on the tick enable falls.
    assign tick       = clk7_en && (state == ACCUM || enable);
    assign terminal   = tick && (cnt == '1);
    assign pop        = out_valid && out_ready;
    assign full       = (count == (PW+1)'(FIFO_DEPTH));
    assign push       = terminal && (!full || pop);
    assign drop       = terminal && full && !pop;
    assign count_next = count + (PW+1)'(push) - (PW+1)'(pop);

    assign out_left  = mem[rd_ptr][31:16];
    assign out_right = mem[rd_ptr][15:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            lacc      <= '0;
            racc      <= '0;
            cnt       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state <= enable ? ACCUM : IDLE;

            if (terminal || !enable) begin
                lacc <= '0;
                racc <= '0;
                cnt  <= '0;
            end else if (tick) begin
                lacc <= lsum;
                racc <= rsum;
                cnt  <= cnt + DECIM_LOG2'(1);
            end

            if (push) begin
                mem[wr_ptr] <= {lavg, 1'b0, ravg, 1'b0};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_next;

            // A word written into an empty FIFO becomes visible one edge later.
            out_valid <= (count != '0) && (count_next != '0);

            overflow <= drop;
            if (drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_paula_audio_decimator.sv
// Self-checking bench for paula_audio_decimator (DECIM_LOG2=3, FIFO_DEPTH=4).
module tb_paula_audio_decimator;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clk7_en = 1'b0;
    logic        enable = 1'b0;
    logic [14:0] ldatasum = '0;
    logic [14:0] rdatasum = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [15:0] out_left;
    logic [15:0] out_right;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    paula_audio_decimator #(.DECIM_LOG2(3), .FIFO_DEPTH(4)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .clk7_en(clk7_en),
        .enable(enable),
        .ldatasum(ldatasum),
        .rdatasum(rdatasum),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_left(out_left),
        .out_right(out_right),
        .overflow(overflow),
        .drop_cnt(drop_cnt)
    );

    typedef struct {
        logic [14:0] l0;
        logic [14:0] ls;
        logic [14:0] r0;
        logic [14:0] rs;
        logic [15:0] exp_l;
        logic [15:0] exp_r;
    } vec_t;

    typedef struct {
        logic [31:0] w;
        int          stamp;
    } ent_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            ldatasum = 15'($urandom);
            rdatasum = 15'($urandom);
            step();
        end
    endtask

    task automatic tick(input logic [14:0] l, input logic [14:0] r,
                        input bit rdy);
        ldatasum = l;
        rdatasum = r;
        clk7_en  = 1'b1;
        if (rdy) out_ready = 1'b1;
        step();
        clk7_en = 1'b0;
        if (rdy) out_ready = 1'b0;
    endtask

    // Eight ticks; returns just after the terminal-tick edge.
    task automatic window(input logic [14:0] l0, input logic [14:0] ls,
                          input logic [14:0] r0, input logic [14:0] rs,
                          input bit rdy_last);
        for (int i = 0; i < 8; i++) begin
            tick(l0 + 15'(i) * ls, r0 + 15'(i) * rs, (i == 7) && rdy_last);
            if (i < 7) gap(3);
        end
    endtask

    task automatic wait_word(input string name, input logic [15:0] el,
                             input logic [15:0] er);
        int  n;
        bit  r;
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_left"}, 32'(out_left), 32'(el));
        chk({name, "_right"}, 32'(out_right), 32'(er));
        r = out_ready;
        out_ready = 1'b1;
        step();
        out_ready = r;
    endtask

    function automatic int fdiv8(input int s);
        return (s - (((s % 8) + 8) % 8)) / 8;
    endfunction

    vec_t vecs[6];

    initial begin
        int   m;
        int   drops;
        int   wl[$];
        int   wr[$];
        ent_t q[$];
        bit   mv;
        bit   pop;
        bit   full_before;
        bit   was_empty;
        bit   exp_ovf;
        int   sl;
        int   sr;
        logic [15:0] el;
        logic [15:0] er;

        vecs[0] = '{15'h0100, 15'h0000, 15'h7F00, 15'h0000, 16'h0200, 16'hFE00};
        vecs[1] = '{15'h0000, 15'h0001, 15'h7FFF, 15'h0000, 16'h0006, 16'hFFFE};
        vecs[2] = '{15'h3FFF, 15'h0000, 15'h4000, 15'h0000, 16'h7FFE, 16'h8000};
        vecs[3] = '{15'h7FFF, 15'h7FFF, 15'h0001, 15'h0000, 16'hFFF6, 16'h0002};
        vecs[4] = '{15'h0005, 15'h0000, 15'h0003, 15'h0001, 16'h000A, 16'h000C};
        vecs[5] = '{15'h4000, 15'h0800, 15'h0001, 15'h7FFE, 16'hB800, 16'hFFF4};

        // Reset state
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_left", 32'(out_left), 32'd0);
        chk("rst_right", 32'(out_right), 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // First word timing: valid one edge after the write edge
        enable = 1'b1;
        out_ready = 1'b1;
        gap(2);
        for (int i = 0; i < 7; i++) begin
            tick(15'h0100, 15'h7F00, 1'b0);
            gap(3);
        end
        tick(15'h0100, 15'h7F00, 1'b0);
        chk("t31_valid_at_write", 32'(out_valid), 32'd0);
        step();
        chk("t31_valid_rise", 32'(out_valid), 32'd1);
        chk("t31_left", 32'(out_left), 32'h0200);
        chk("t31_right", 32'(out_right), 32'hFE00);
        chk("t31_ovf", 32'(overflow), 32'd0);
        step();
        chk("t31_valid_after_pop", 32'(out_valid), 32'd0);
        gap(3);

        // Table-driven windows
        foreach (vecs[i]) begin
            window(vecs[i].l0, vecs[i].ls, vecs[i].r0, vecs[i].rs, 1'b0);
            wait_word($sformatf("vec%0d", i), vecs[i].exp_l, vecs[i].exp_r);
            gap(3);
        end

        // Five windows into a 4-deep FIFO with no consumer
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            window(15'(k), 15'd0, 15'(-k), 15'd0, 1'b0);
            chk($sformatf("fill%0d_ovf", k), 32'(overflow), 32'(k == 5));
            if (k < 5) gap(3);
        end
        chk("fill_drop_cnt", 32'(drop_cnt), 32'd1);
        chk("fill_head", 32'(out_left), 32'h0002);
        step();
        chk("fill_ovf_one_cycle", 32'(overflow), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            wait_word($sformatf("drain%0d", k), 16'(2 * k), 16'(-2 * k));
        end
        gap(3);
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Full FIFO, pop coinciding with the terminal tick
        for (int k = 6; k <= 9; k++) begin
            window(15'(k), 15'd0, 15'(-k), 15'd0, 1'b0);
            gap(3);
        end
        window(15'd10, 15'd0, 15'(-10), 15'd0, 1'b1);
        chk("pp_ovf", 32'(overflow), 32'd0);
        chk("pp_valid", 32'(out_valid), 32'd1);
        chk("pp_head", 32'(out_left), 32'd14);
        for (int k = 7; k <= 10; k++) begin
            wait_word($sformatf("pp_drain%0d", k), 16'(2 * k), 16'(-2 * k));
        end
        gap(3);
        chk("pp_empty", 32'(out_valid), 32'd0);
        chk("pp_drop_cnt", 32'(drop_cnt), 32'd1);

        // Partial window discarded when enable drops
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(15'd100, 15'd100, 1'b0);
            gap(3);
        end
        enable = 1'b0;
        gap(6);
        chk("part_no_word", 32'(out_valid), 32'd0);
        enable = 1'b1;
        gap(2);
        window(15'd7, 15'd0, 15'(-7), 15'd0, 1'b0);
        wait_word("reen", 16'd14, 16'hFFF2);
        gap(3);

        // enable falling on the terminal tick still emits the sample
        for (int i = 0; i < 7; i++) begin
            tick(15'd9, 15'd9, 1'b0);
            gap(3);
        end
        enable = 1'b0;
        tick(15'd9, 15'd9, 1'b0);
        wait_word("en_fall", 16'd18, 16'd18);
        gap(12);
        chk("en_fall_idle", 32'(out_valid), 32'd0);
        enable = 1'b1;
        gap(2);

        // Reset mid-window with two words queued
        out_ready = 1'b0;
        window(15'd3, 15'd0, 15'd3, 15'd0, 1'b0);
        gap(3);
        window(15'd4, 15'd0, 15'd4, 15'd0, 1'b0);
        gap(3);
        for (int i = 0; i < 3; i++) begin
            tick(15'd50, 15'd50, 1'b0);
            gap(3);
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_drop", 32'(drop_cnt), 32'd0);
        chk("mrst_left", 32'(out_left), 32'd0);
        step();
        reset_n = 1'b1;
        out_ready = 1'b1;
        gap(2);
        window(15'd11, 15'd0, 15'(-11), 15'd0, 1'b0);
        wait_word("post_rst", 16'd22, 16'hFFEA);

        // Randomised run against a queue-based reference
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        clk7_en = 1'b0;
        out_ready = 1'b0;
        enable = 1'b1;
        step();
        m = 0;
        drops = 0;
        for (int c = 0; c < 3000; c++) begin
            mv = (q.size() > 0) && (q[0].stamp < m);
            chk("rnd_valid", 32'(out_valid), 32'(mv));
            if (mv) chk("rnd_word", {out_left, out_right}, q[0].w);

            clk7_en = ($urandom_range(0, 3) == 0);
            ldatasum = 15'($urandom);
            rdatasum = 15'($urandom);
            if (c < 1500) out_ready = ($urandom_range(0, 63) == 0);
            else out_ready = 1'($urandom_range(0, 1));

            pop = mv && out_ready;
            full_before = (q.size() == 4);
            was_empty = (q.size() == 0);
            exp_ovf = 1'b0;
            if (pop) void'(q.pop_front());
            if (clk7_en) begin
                wl.push_back(int'($signed(ldatasum)));
                wr.push_back(int'($signed(rdatasum)));
                if (wl.size() == 8) begin
                    sl = 0;
                    sr = 0;
                    foreach (wl[j]) begin
                        sl += wl[j];
                        sr += wr[j];
                    end
                    wl.delete();
                    wr.delete();
                    el = 16'(fdiv8(sl) * 2);
                    er = 16'(fdiv8(sr) * 2);
                    if (full_before && !pop) begin
                        exp_ovf = 1'b1;
                        drops++;
                    end else begin
                        q.push_back('{{el, er}, was_empty ? m + 1 : -1});
                    end
                end
            end
            step();
            m++;
            chk("rnd_ovf", 32'(overflow), 32'(exp_ovf));
        end
        chk("rnd_drop_cnt", 32'(drop_cnt), 32'(drops > 255 ? 255 : drops));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
